// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM encoding,
// AXI-Lite constants and the reset fetch address.
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

   localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
   localparam logic [2:0]  ARPROT_INST      = 3'b100;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
   localparam int          PC_STEP          = 4;

   // Instructions are word aligned; any low address bit set is a fetch fault.
   function automatic logic is_misaligned(input logic [1:0] pc_lsb);
      return (pc_lsb != 2'b00);
   endfunction

endpackage

// File: rtl/fetch_ctrl_pc_next_sel.sv
// Redirect priority and sequential-address generation for the fetch PC.
// Flush beats branch when both are raised in the same cycle.
module fetch_ctrl_pc_next_sel
   import fetch_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_pc,
   input  logic              branch_valid,
   input  logic [ADDR_W-1:0] branch_target,
   output logic              redirect,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] pc_seq
);

   // Redirect mux and +4; the add wraps silently at the top of the space.
   always_comb begin
      redirect    = flush | branch_valid;
      redirect_pc = flush ? flush_pc : branch_target;
      pc_seq      = pc + ADDR_W'(PC_STEP);
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one AXI-Lite read at a
// time and hands each instruction to decode through a single holding entry.
//
//   state | meaning
//   IDLE  | no request; waits out stall, absorbs redirects
//   ADDR  | AR valid presented, address frozen until arready
//   DATA  | waiting for the R beat; a stale beat is dropped
//   HOLD  | instruction presented to decode until inst_ready
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_pc,
   input  logic              branch_valid,
   input  logic [ADDR_W-1:0] branch_target,
   output logic              m_arvalid,
   output logic [ADDR_W-1:0] m_araddr,
   output logic [2:0]        m_arprot,
   input  logic              m_arready,
   input  logic              m_rvalid,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic [1:0]        m_rresp,
   output logic              m_rready,
   output logic              inst_valid,
   output logic [DATA_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              inst_err,
   input  logic              inst_ready
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              discard_q, discard_d;
   logic [ADDR_W-1:0] ar_addr_q;
   logic [DATA_W-1:0] inst_q;
   logic [ADDR_W-1:0] inst_pc_q;
   logic              inst_err_q;

   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic [ADDR_W-1:0] pc_seq;

   logic              go_fetch;
   logic              start_ar;
   logic              cap_beat;
   logic              cap_misalign;

   fetch_ctrl_pc_next_sel #(
      .ADDR_W (ADDR_W)
   ) u_pc_next_sel (
      .pc            (pc_q),
      .flush         (flush),
      .flush_pc      (flush_pc),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .pc_seq        (pc_seq)
   );

   // Next-state, next-PC and capture strobes for the fetch sequence.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      discard_d    = discard_q;
      go_fetch     = 1'b0;
      start_ar     = 1'b0;
      cap_beat     = 1'b0;
      cap_misalign = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (redirect) begin
               pc_d = redirect_pc;
            end else if (!stall) begin
               go_fetch = 1'b1;
            end
         end

         ADDR: begin
            // The AR already on the bus cannot be withdrawn, so a redirect
            // only marks its eventual response as stale.
            if (redirect) begin
               pc_d      = redirect_pc;
               discard_d = 1'b1;
            end
            if (m_arready) begin
               state_d = DATA;
            end
         end

         DATA: begin
            if (m_rvalid) begin
               if (discard_q || redirect) begin
                  discard_d = 1'b0;
                  state_d   = IDLE;
                  if (redirect) begin
                     pc_d = redirect_pc;
                  end
               end else begin
                  cap_beat = 1'b1;
                  pc_d     = pc_seq;
                  state_d  = HOLD;
               end
            end else if (redirect) begin
               pc_d      = redirect_pc;
               discard_d = 1'b1;
            end
         end

         HOLD: begin
            if (redirect) begin
               pc_d    = redirect_pc;
               state_d = IDLE;
            end else if (inst_ready) begin
               if (stall) begin
                  state_d = IDLE;
               end else begin
                  go_fetch = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // A misaligned PC never reaches the bus; it is reported straight to
      // decode as a faulting instruction at the same PC.
      if (go_fetch) begin
         if (is_misaligned(pc_q[1:0])) begin
            state_d      = HOLD;
            cap_misalign = 1'b1;
         end else begin
            state_d  = ADDR;
            start_ar = 1'b1;
         end
      end
   end

   // Control state: FSM, PC and the stale-response marker.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         discard_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         discard_q <= discard_d;
      end
   end

   // AR address is latched on entry to ADDR so a redirect cannot disturb it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ar_addr_q <= '0;
      end else if (start_ar) begin
         ar_addr_q <= pc_q;
      end
   end

   // Holding entry presented to decode.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inst_q     <= '0;
         inst_pc_q  <= '0;
         inst_err_q <= 1'b0;
      end else if (cap_beat) begin
         inst_q     <= m_rdata;
         inst_pc_q  <= pc_q;
         inst_err_q <= (m_rresp != AXI_RESP_OKAY);
      end else if (cap_misalign) begin
         inst_q     <= '0;
         inst_pc_q  <= pc_q;
         inst_err_q <= 1'b1;
      end else if (state_d != HOLD) begin
         inst_err_q <= 1'b0;
      end
   end

   // Bus and decode-side outputs decode directly from the state.
   always_comb begin
      m_arvalid  = (state_q == ADDR);
      m_araddr   = ar_addr_q;
      m_arprot   = ARPROT_INST;
      m_rready   = (state_q == DATA);
      inst_valid = (state_q == HOLD);
      inst       = inst_q;
      inst_pc    = inst_pc_q;
      inst_err   = inst_err_q;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer that owns the program counter and drives the instruction-side AXI-Lite read channel (AR/R) of the SoC. It issues one outstanding read per instruction. It applies redirects with the priority exception flush > branch > sequential PC+4, and hands {inst, inst_pc} to decode over a valid/ready interface. It replaces free-running PC increment with a request/response-paced sequence.

Parameters:
RESET_PC, 32'hBFC0_0000, first fetch address after reset
ADDR_W, 32, PC / araddr width
DATA_W, 32, instruction width

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  inhibits issuing a new AR request; an outstanding read still completes
flush  in  1  exception/eret redirect, highest priority
flush_pc  in  ADDR_W  flush target
branch_valid  in  1  branch/jump redirect
branch_target  in  ADDR_W  branch target
m_arvalid  out  1  AXI-Lite AR valid
m_araddr  out  ADDR_W  AXI-Lite AR address (= pc)
m_arprot  out  3  constant 3'b100 (instruction access)
m_arready  in  1  AXI-Lite AR ready
m_rvalid  in  1  AXI-Lite R valid
m_rdata  in  DATA_W  AXI-Lite R data
m_rresp  in  2  AXI-Lite R response
m_rready  out  1  AXI-Lite R ready
inst_valid  out  1  instruction available to decode
inst  out  DATA_W  instruction word
inst_pc  out  ADDR_W  address of inst
inst_err  out  1  qualifies inst_valid: bus error (rresp != 2'b00) or misaligned pc
inst_ready  in  1  decode accepts

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_PC, state=IDLE, discard=0, all outputs 0 except m_arprot.
- States:
  - IDLE: stay while stall. Otherwise go to ADDR next cycle. The first m_arvalid appears one cycle after rst deassertion.
  - ADDR: m_arvalid=1, m_araddr=pc. Both held stable until m_arready (AXI rule; never withdrawn). On the handshake cycle go to DATA.
  - DATA: m_rready=1. On m_rvalid:
    - If discard=1: drop the beat, clear discard, go to IDLE with pc already redirected.
    - Else: load inst=m_rdata, inst_pc=pc, inst_err=(m_rresp!=0), inst_valid=1; pc<=pc+4; go to HOLD.
  - HOLD: inst_valid=1 until inst_ready. On the acceptance cycle clear inst_valid and go to ADDR, or to IDLE if stall. No new AR is issued while an instruction is unconsumed (single entry, no skid).
- Redirect target = flush ? flush_pc : branch_target (flush wins on a simultaneous assertion).
  - In IDLE or HOLD: pc<=target, inst_valid<=0 immediately (the held instruction is squashed), go to IDLE.
  - In ADDR or DATA: pc<=target, discard<=1. The current transaction runs to completion and its response is dropped. A second redirect before the response overwrites pc; discard stays 1.
  - A redirect in the same cycle as the DATA response beat: the beat is dropped, pc<=target, go to IDLE.
- Misaligned pc (pc[1:0]!=0) on entry to ADDR: no AR is issued. Present inst_valid=1, inst_err=1, inst=0, inst_pc=pc directly in HOLD; pc is not incremented.
- pc+4 wraps modulo 2^ADDR_W with no flag.
- stall is sampled only in IDLE and on the HOLD exit; it never affects an outstanding transaction.
- Throughput: 1 instruction per 3 cycles minimum (ADDR, DATA, HOLD with zero-wait slave and inst_ready=1).

Decomposition:
- Shared package/header (alongside the global/rom defines): state encoding (IDLE, ADDR, DATA, HOLD), AXI_RESP_OKAY=2'b00, ARPROT_INST=3'b100, and RESET_PC default.
- A separate pc_next_sel sub-module (combinational redirect priority mux plus +4) is natural. All state remains in fetch_ctrl.

Test Plan:
1. Reset release, zero-wait slave returning rdata=addr^32'hFFFF_FFFF, inst_ready=1 -> AR addresses BFC00000, BFC00004, BFC00008 in order; inst_pc matches each; inst_valid pulses every 3 cycles.
2. m_arready held low 5 cycles with branch_valid=1, target 8000_0100 pulsed during ADDR -> m_araddr stays BFC00000 and stable until the handshake; that response is dropped; next AR is 8000_0100.
3. flush (flush_pc=BFC00380) and branch_valid (target 8000_0000) in the same cycle during DATA -> next AR is BFC00380; no inst_valid for the dropped beat.
4. inst_ready low 4 cycles in HOLD -> inst/inst_pc stable and m_arvalid=0 throughout; a single AR is issued after acceptance.
5. Slave returns rresp=2'b10 at pc 8000_0010 -> inst_valid=1, inst_err=1, inst_pc=8000_0010; next AR is 8000_0014.
6. branch to 8000_0002 -> no AR; inst_valid=1, inst_err=1, inst_pc=8000_0002. Separately, rst asserted mid-DATA -> all outputs 0 asynchronously, and after release the first AR is BFC00000.
